// File: rtl/rgb_pwm_pkg.sv
// Shared types and channel indexing for the RGB PWM driver.
package rgb_pwm_pkg;

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} pwm_state_t;

  localparam int R      = 0;
  localparam int G      = 1;
  localparam int B      = 2;
  localparam int NUM_CH = 3;

  // Source-side carrier for a duty triple; wide enough for any practical period.
  localparam int DUTY_W_MAX = 16;
  typedef struct packed {
    logic [DUTY_W_MAX-1:0] r;
    logic [DUTY_W_MAX-1:0] g;
    logic [DUTY_W_MAX-1:0] b;
  } duty_triple_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel with a registered active-low pin.
module pwm_channel #(
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] cnt,
  input  logic [DW-1:0] duty,
  input  logic          enable,
  output logic          pin_n
);

  logic on;

  // Duties at or above the period length saturate to always-on naturally.
  assign on = enable && (cnt < duty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_n <= 1'b1;
    end else begin
      pin_n <= ~on;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM LED driver; duty updates are double-buffered to period boundaries.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int DW           = $clog2(PWM_INTERVAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] duty_r,
  input  logic [DW-1:0] duty_g,
  input  logic [DW-1:0] duty_b,
  input  logic          duty_valid,
  output logic          duty_ready,
  input  logic          enable,
  output logic          period_start,
  output logic          red_n,
  output logic          green_n,
  output logic          blue_n
);

  localparam logic [DW-1:0] CNT_LAST = DW'(PWM_INTERVAL - 1);

  logic [DW-1:0]             cnt_reg;
  logic                      last;
  logic                      period_start_reg;
  logic                      xfer;
  pwm_state_t                state_reg, state_next;
  logic [NUM_CH-1:0][DW-1:0] duty_in;
  logic [NUM_CH-1:0][DW-1:0] pending_reg;
  logic [NUM_CH-1:0][DW-1:0] active_reg;
  logic [NUM_CH-1:0]         pins_n;

  assign duty_in[R] = duty_r;
  assign duty_in[G] = duty_g;
  assign duty_in[B] = duty_b;

  assign last = (cnt_reg == CNT_LAST);
  assign xfer = duty_valid && duty_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg          <= '0;
      period_start_reg <= 1'b0;
    end else begin
      cnt_reg          <= last ? '0 : cnt_reg + 1'b1;
      period_start_reg <= (cnt_reg == '0);
    end
  end

  assign period_start = period_start_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (xfer && !last) state_next = PENDING;
      PENDING: if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    duty_ready = rst_n && (state_reg == IDLE);
  end

  // A transfer landing on the last cycle bypasses the pending buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= '0;
      active_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            if (last) active_reg  <= duty_in;
            else      pending_reg <= duty_in;
          end
        end
        PENDING: begin
          if (last) active_reg <= pending_reg;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pwm_channel #(.DW(DW)) u_ch (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt    (cnt_reg),
        .duty   (active_reg[gi]),
        .enable (enable),
        .pin_n  (pins_n[gi])
      );
    end
  endgenerate

  assign red_n   = pins_n[R];
  assign green_n = pins_n[G];
  assign blue_n  = pins_n[B];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench: an 8-cycle-period driver plus a 6-cycle one for saturation.
module tb_rgb_pwm_driver;

  logic       clk;
  logic       rst_n;
  logic [2:0] duty_r, duty_g, duty_b;
  logic       duty_valid, enable;
  logic       duty_ready, period_start, red_n, green_n, blue_n;

  logic [2:0] d6_r, d6_g, d6_b;
  logic       d6_valid, d6_ready, d6_ps, d6_red_n, d6_green_n, d6_blue_n;

  int errors = 0;
  int checks = 0;
  int tb_cnt = 0;

  rgb_pwm_driver #(.PWM_INTERVAL(8), .DW(3)) dut (
    .clk(clk), .rst_n(rst_n), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .enable(enable),
    .period_start(period_start), .red_n(red_n), .green_n(green_n), .blue_n(blue_n)
  );

  rgb_pwm_driver #(.PWM_INTERVAL(6), .DW(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .duty_r(d6_r), .duty_g(d6_g), .duty_b(d6_b),
    .duty_valid(d6_valid), .duty_ready(d6_ready), .enable(1'b1),
    .period_start(d6_ps), .red_n(d6_red_n), .green_n(d6_green_n), .blue_n(d6_blue_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected period position of the 8-cycle DUT, as seen between edges.
  always @(posedge clk) begin
    if (!rst_n) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == 7) ? 0 : tb_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic wait_cnt(input int k);
    int n = 0;
    while (tb_cnt != k && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (tb_cnt != k) check("wait_cnt_timeout", tb_cnt, k);
  endtask

  // Low-cycle counts per pin over one full period of compare values 0..7.
  task automatic measure(output int lr, output int lg, output int lb);
    wait_cnt(1);
    lr = 0; lg = 0; lb = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      lr += (red_n   == 1'b0) ? 1 : 0;
      lg += (green_n == 1'b0) ? 1 : 0;
      lb += (blue_n  == 1'b0) ? 1 : 0;
    end
  endtask

  task automatic set_duty(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
    duty_r = r; duty_g = g; duty_b = b;
  endtask

  task automatic sat_run(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                         input int er, input int eg, input int eb, input string tag);
    int n = 0;
    int lr = 0, lg = 0, lb = 0;
    d6_r = r; d6_g = g; d6_b = b; d6_valid = 1'b1;
    #1;
    while (!d6_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, d6_ready, 1);
    @(negedge clk);
    d6_valid = 1'b0;
    repeat (14) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      lr += (d6_red_n   == 1'b0) ? 1 : 0;
      lg += (d6_green_n == 1'b0) ? 1 : 0;
      lb += (d6_blue_n  == 1'b0) ? 1 : 0;
    end
    check({tag, "_r_low"}, lr, er);
    check({tag, "_g_low"}, lg, eg);
    check({tag, "_b_low"}, lb, eb);
  endtask

  int lr, lg, lb, ps_cnt;

  initial begin
    rst_n = 1'b0; enable = 1'b1; duty_valid = 1'b1; set_duty(3'd6, 3'd6, 3'd6);
    d6_r = '0; d6_g = '0; d6_b = '0; d6_valid = 1'b0;

    // Reset held three cycles; valid during reset must not be taken.
    repeat (3) @(negedge clk);
    check("rst_red_n", red_n, 1);
    check("rst_green_n", green_n, 1);
    check("rst_blue_n", blue_n, 1);
    check("rst_ready", duty_ready, 0);
    check("rst_period_start", period_start, 0);
    duty_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_ready", duty_ready, 1);
    check("rel_ps_cnt0", period_start, 0);
    @(negedge clk);
    check("rel_ps_first", period_start, 1);
    @(negedge clk);
    check("rel_ps_drop", period_start, 0);
    ps_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ps_cnt += period_start ? 1 : 0;
    end
    check("ps_once_per_period", ps_cnt, 1);
    measure(lr, lg, lb);
    check("rst_active_r", lr, 0);
    check("rst_active_g", lg, 0);
    check("rst_active_b", lb, 0);

    // Basic duty accepted mid-period, applied at the wrap.
    wait_cnt(2);
    set_duty(3'd3, 3'd0, 3'd7); duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    #1;
    check("basic_ready_low", duty_ready, 0);
    wait_cnt(7);
    check("basic_ready_low_last", duty_ready, 0);
    @(negedge clk);
    check("basic_ready_wrap", duty_ready, 1);
    measure(lr, lg, lb);
    check("basic_r", lr, 3);
    check("basic_g", lg, 0);
    check("basic_b", lb, 7);

    // Transfer on the last cycle bypasses the pending stage.
    wait_cnt(7);
    set_duty(3'd5, 3'd1, 3'd2); duty_valid = 1'b1;
    #1;
    check("bypass_ready_at_last", duty_ready, 1);
    @(negedge clk);
    duty_valid = 1'b0;
    #1;
    check("bypass_ready_stays", duty_ready, 1);
    measure(lr, lg, lb);
    check("bypass_r", lr, 5);
    check("bypass_g", lg, 1);
    check("bypass_b", lb, 2);

    // Valid held with changing data: one triple per period, stalled data ignored.
    wait_cnt(3);
    set_duty(3'd1, 3'd2, 3'd3); duty_valid = 1'b1;
    @(negedge clk); set_duty(3'd6, 3'd6, 3'd6);
    @(negedge clk); set_duty(3'd5, 3'd5, 3'd5);
    @(negedge clk); set_duty(3'd4, 3'd4, 3'd4);
    @(negedge clk); set_duty(3'd7, 3'd7, 3'd7);
    check("bp_ready_stalled", duty_ready, 0);
    @(negedge clk); set_duty(3'd2, 3'd4, 3'd6);
    #1;
    check("bp_ready_reopen", duty_ready, 1);
    @(negedge clk);
    duty_valid = 1'b0;
    #1;
    check("bp_ready_taken", duty_ready, 0);
    measure(lr, lg, lb);
    check("bp_first_r", lr, 1);
    check("bp_first_g", lg, 2);
    check("bp_first_b", lb, 3);
    measure(lr, lg, lb);
    check("bp_second_r", lr, 2);
    check("bp_second_g", lg, 4);
    check("bp_second_b", lb, 6);

    // Enable dropped mid-period: pins off one cycle later, counter keeps going.
    wait_cnt(3);
    enable = 1'b0;
    #1;
    check("en_lag_green", green_n, 0);
    check("en_lag_red", red_n, 1);
    @(negedge clk);
    check("en_off_red", red_n, 1);
    check("en_off_green", green_n, 1);
    check("en_off_blue", blue_n, 1);
    wait_cnt(1);
    check("en_off_ps_runs", period_start, 1);
    check("en_off_blue_hold", blue_n, 1);
    enable = 1'b1;
    @(negedge clk);
    measure(lr, lg, lb);
    check("en_back_r", lr, 2);
    check("en_back_g", lg, 4);
    check("en_back_b", lb, 6);

    // Reset during PENDING discards the pending triple.
    wait_cnt(2);
    set_duty(3'd7, 3'd7, 3'd7); duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    #1;
    check("rp_pending", duty_ready, 0);
    wait_cnt(5);
    rst_n = 1'b0;
    #1;
    check("rp_ready_in_rst", duty_ready, 0);
    @(negedge clk);
    check("rp_red_off", red_n, 1);
    check("rp_green_off", green_n, 1);
    check("rp_blue_off", blue_n, 1);
    check("rp_ps", period_start, 0);
    rst_n = 1'b1;
    #1;
    check("rp_ready_rel", duty_ready, 1);
    measure(lr, lg, lb);
    check("rp_active_r", lr, 0);
    check("rp_active_g", lg, 0);
    check("rp_active_b", lb, 0);
    measure(lr, lg, lb);
    check("rp_next_r", lr, 0);
    check("rp_next_b", lb, 0);

    // Saturation on the 6-cycle instance.
    sat_run(3'd7, 3'd0, 3'd3, 12, 0, 6, "sat7");
    sat_run(3'd6, 3'd6, 3'd1, 12, 12, 2, "sat6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Consumer end of the duty-value interface that the fade/colour sequencers produce. It takes R/G/B duty values through a valid/ready handshake and turns them into three PWM waveforms that drive the board's active-low RGB LED pins.
- New duties are double-buffered and only take effect at a PWM period boundary, so there are never glitched or partial periods.
- Sits between any duty-value source and the top-level LED pins.

Parameters:
- PWM_INTERVAL, 1200, PWM period in clk cycles (100 us at 12 MHz); must be >= 2.
- DW, $clog2(PWM_INTERVAL), width of duty values and the period counter.

Ports:
- clk  in  1  system clock, 12 MHz.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- duty_r  in  DW  requested red duty, in clk cycles high per period.
- duty_g  in  DW  requested green duty.
- duty_b  in  DW  requested blue duty.
- duty_valid  in  1  source presents duty_r/g/b.
- duty_ready  out  1  block can accept a new triple.
- enable  in  1  0 forces all LEDs off; duty state is unaffected.
- period_start  out  1  one-cycle pulse at the start of each PWM period.
- red_n  out  1  red LED drive, active-low.
- green_n  out  1  green LED drive, active-low.
- blue_n  out  1  blue LED drive, active-low.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - cnt=0; active duties=0; pending duties=0; state=IDLE.
  - red_n/green_n/blue_n=1 (off); period_start=0.
  - duty_ready=0 while rst_n=0.
- Period counter:
  - cnt counts 0..PWM_INTERVAL-1, then wraps to 0.
  - last = (cnt==PWM_INTERVAL-1).
  - period_start is registered: it is 1 in the cycle after cnt==0 was present, so it pulses exactly once per period.
- Handshake:
  - duty_ready = rst_n && (state==IDLE), combinational from state.
  - Transfer occurs when duty_valid && duty_ready at a posedge.
  - Data is sampled only on transfer. duty_valid while ready=0 is ignored; the source must hold it.
- FSM, 2 states:
  - IDLE:
    - Transfer with last=0: pending <= inputs; go to PENDING.
    - Transfer with last=1 (simultaneous boundary): active <= inputs directly (bypass); stay IDLE.
  - PENDING:
    - last=1: active <= pending; go to IDLE. duty_ready rises the next cycle.
    - Otherwise hold.
  - Worst-case accept-to-apply latency is PWM_INTERVAL cycles. At most one update is applied per period.
- Compare, per channel c:
  - on_c = enable && (cnt < active_c). Compare is unsigned at DW bits.
  - c_n <= ~on_c, registered, so the pin lags cnt by 1 cycle.
  - active_c=0: always off. active_c >= PWM_INTERVAL: always on (saturates; no wrap).
- enable:
  - Takes effect on the pins 1 cycle after it changes.
  - Does not stall the counter or the handshake.
- Reset mid-period or mid-PENDING discards pending data; outputs go off on the next edge.
- All logic is on posedge clk; no derived clocks or edges on data signals.

Decomposition:
- Package rgb_pwm_pkg:
  - typedef enum logic {IDLE, PENDING} pwm_state_t;
  - localparam channel indices R=0, G=1, B=2;
  - typedef for a duty triple struct.
- Sub-module pwm_channel (parameter DW):
  - Inputs: clk, rst_n, cnt, duty, enable.
  - Output: registered active-low pin.
  - Instantiated three times.
- The counter and FSM stay in rgb_pwm_driver.

Test Plan (PWM_INTERVAL=8, DW=3 unless noted):
- Reset: hold rst_n=0 for 3 cycles -> red_n/green_n/blue_n=1, duty_ready=0, period_start=0. Release -> duty_ready=1; first period_start pulse 1 cycle after cnt=0.
- Basic duty: send r=3,g=0,b=7 with cnt=2 -> duty_ready=0 until cnt wraps. In the next period: red_n low for exactly 3 cycles, green_n high all 8, blue_n low 7 of 8. duty_ready=1 again at cnt=0.
- Boundary bypass: assert valid with r=5 exactly at cnt=7 -> duty_ready stays 1; red_n low for 5 cycles starting in the very next period.
- Back-pressure: keep duty_valid=1 with changing data across a period -> only one triple is accepted per period. Values presented while ready=0 never appear on the outputs.
- Saturation: PWM_INTERVAL=6, DW=3, r=7 -> red_n low continuously; r=6 -> also continuously low.
- Enable/reset mid-op: drop enable mid-period -> all pins high 1 cycle later and the counter keeps running. Pulse rst_n=0 while PENDING -> pending triple is discarded and active duties read 0 after release.
